// File: rtl/axis_image_vip_pkg.sv
// -----------------------------------------------------------------------------
// axis_image_vip_pkg
// Shared definitions for the AXI-Stream skid pipeline:
//   - legal ranges for payload width and stage count
//   - slot_ctl_t: sideband/valid portion of one stage slot {last, user, valid}
//   - params_ok(): elaboration-time legality check for the top parameters
// No ports (package).
// -----------------------------------------------------------------------------
package axis_image_vip_pkg;

   localparam int MIN_DATA_BYTES = 1;
   localparam int MAX_DATA_BYTES = 64;
   localparam int MIN_STAGES     = 1;
   localparam int MAX_STAGES     = 16;

   // The payload width is a module parameter, so the full slot type is built
   // inside the stage as {data, slot_ctl_t}; this is the width-independent part.
   typedef struct packed {
      logic last;
      logic user;
      logic valid;
   } slot_ctl_t;

   localparam slot_ctl_t SLOT_CTL_EMPTY = '{last: 1'b0, user: 1'b0, valid: 1'b0};

   function automatic logic params_ok(input int data_bytes, input int stages);
      return (data_bytes >= MIN_DATA_BYTES) && (data_bytes <= MAX_DATA_BYTES) &&
             (stages >= MIN_STAGES) && (stages <= MAX_STAGES);
   endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// -----------------------------------------------------------------------------
// axis_skid_stage
// One register stage with a main slot and a skid slot. The upstream ready is
// a flop equal to NOT(skid valid), so there is no combinational path from
// out_ready_i to in_ready_o.
// Ports:
//   clk_i, rstn_i                    clock, async active-low reset
//   in_data_i/valid_i/last_i/user_i  upstream beat
//   in_ready_o                       upstream ready (registered)
//   out_data_o/valid_o/last_o/user_o downstream beat (main slot)
//   out_ready_i                      downstream ready
// -----------------------------------------------------------------------------
module axis_skid_stage
   import axis_image_vip_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [DATA_BITS-1:0] in_data_i,
   input  logic                 in_valid_i,
   input  logic                 in_last_i,
   input  logic                 in_user_i,
   output logic                 in_ready_o,
   output logic [DATA_BITS-1:0] out_data_o,
   output logic                 out_valid_o,
   output logic                 out_last_o,
   output logic                 out_user_o,
   input  logic                 out_ready_i
);

   typedef struct packed {
      logic [DATA_BITS-1:0] data;
      slot_ctl_t            ctl;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '{data: {DATA_BITS{1'b0}}, ctl: SLOT_CTL_EMPTY};

   slot_t main_q, main_d;
   slot_t skid_q, skid_d;
   slot_t in_slot_s;
   logic  ready_q, ready_d;
   logic  accept_s, emit_s;

   assign accept_s = in_valid_i & ready_q;
   assign emit_s   = main_q.ctl.valid & out_ready_i;

   // Wrap the incoming beat as a filled slot.
   always_comb begin
      in_slot_s.data      = in_data_i;
      in_slot_s.ctl.last  = in_last_i;
      in_slot_s.ctl.user  = in_user_i;
      in_slot_s.ctl.valid = 1'b1;
   end

   // Slot next-state: ready_q == !skid valid, so accept never coincides with a full skid.
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (skid_q.ctl.valid) begin
         if (emit_s) begin
            // Main leaves downstream; skid refills main on the same edge.
            main_d           = skid_q;
            skid_d.ctl.valid = 1'b0;
         end else begin
            main_d = main_q;
         end
      end else if (accept_s) begin
         if (!main_q.ctl.valid || emit_s) begin
            main_d = in_slot_s;
         end else begin
            skid_d = in_slot_s;
         end
      end else if (emit_s) begin
         main_d.ctl.valid = 1'b0;
      end else begin
         main_d = main_q;
      end
      ready_d = ~skid_d.ctl.valid;
   end

   // Slot and ready registers; ready stays low in reset and rises on the first edge after.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         main_q  <= SLOT_EMPTY;
         skid_q  <= SLOT_EMPTY;
         ready_q <= 1'b0;
      end else begin
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   assign in_ready_o  = ready_q;
   assign out_data_o  = main_q.data;
   assign out_valid_o = main_q.ctl.valid;
   assign out_last_o  = main_q.ctl.last;
   assign out_user_o  = main_q.ctl.user;

endmodule

// File: rtl/axis_pipe_skid.sv
// -----------------------------------------------------------------------------
// axis_pipe_skid
// AXI-Stream register pipeline of PIPELINE_STAGES skid stages with a
// registered occupancy count (0..2*PIPELINE_STAGES).
// Ports:
//   clk_i, rstn_i                         clock, async active-low reset
//   axis_s_data_i/valid_i/last_i/user_i   slave beat in
//   axis_s_ready_o                        slave ready (registered)
//   axis_m_data_o/valid_o/last_o/user_o   master beat out
//   axis_m_ready_i                        downstream ready
//   occupancy_o                           beats currently held
// -----------------------------------------------------------------------------
`ifndef SOURCE_BYTES
`define SOURCE_BYTES 3
`endif

module axis_pipe_skid
   import axis_image_vip_pkg::*;
#(
   parameter int DATA_BYTES      = `SOURCE_BYTES,
   parameter int DATA_BITS       = DATA_BYTES * 8,
   parameter int PIPELINE_STAGES = 2,
   parameter int OCC_BITS        = $clog2(2 * PIPELINE_STAGES + 1)
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [DATA_BITS-1:0] axis_s_data_i,
   input  logic                 axis_s_valid_i,
   output logic                 axis_s_ready_o,
   input  logic                 axis_s_last_i,
   input  logic                 axis_s_user_i,
   output logic [DATA_BITS-1:0] axis_m_data_o,
   output logic                 axis_m_valid_o,
   input  logic                 axis_m_ready_i,
   output logic                 axis_m_last_o,
   output logic                 axis_m_user_o,
   output logic [OCC_BITS-1:0]  occupancy_o
);

   if (!params_ok(DATA_BYTES, PIPELINE_STAGES) || (DATA_BITS != DATA_BYTES * 8)) begin : g_bad_params
      $error("axis_pipe_skid: DATA_BYTES/PIPELINE_STAGES out of range or DATA_BITS overridden");
   end

   // Link k feeds stage k; link PIPELINE_STAGES is the master port.
   logic [DATA_BITS-1:0]     link_data_s [PIPELINE_STAGES+1];
   logic [PIPELINE_STAGES:0] link_valid_s;
   logic [PIPELINE_STAGES:0] link_last_s;
   logic [PIPELINE_STAGES:0] link_user_s;
   logic [PIPELINE_STAGES:0] link_ready_s;

   assign link_data_s[0]                = axis_s_data_i;
   assign link_valid_s[0]               = axis_s_valid_i;
   assign link_last_s[0]                = axis_s_last_i;
   assign link_user_s[0]                = axis_s_user_i;
   assign link_ready_s[PIPELINE_STAGES] = axis_m_ready_i;

   for (genvar k = 0; k < PIPELINE_STAGES; k++) begin : g_stage
      axis_skid_stage #(
         .DATA_BITS (DATA_BITS)
      ) u_stage (
         .clk_i       (clk_i),
         .rstn_i      (rstn_i),
         .in_data_i   (link_data_s[k]),
         .in_valid_i  (link_valid_s[k]),
         .in_last_i   (link_last_s[k]),
         .in_user_i   (link_user_s[k]),
         .in_ready_o  (link_ready_s[k]),
         .out_data_o  (link_data_s[k+1]),
         .out_valid_o (link_valid_s[k+1]),
         .out_last_o  (link_last_s[k+1]),
         .out_user_o  (link_user_s[k+1]),
         .out_ready_i (link_ready_s[k+1])
      );
   end

   assign axis_s_ready_o = link_ready_s[0];
   assign axis_m_data_o  = link_data_s[PIPELINE_STAGES];
   assign axis_m_valid_o = link_valid_s[PIPELINE_STAGES];
   assign axis_m_last_o  = link_last_s[PIPELINE_STAGES];
   assign axis_m_user_o  = link_user_s[PIPELINE_STAGES];

   logic                in_hs_s, out_hs_s;
   logic [OCC_BITS-1:0] occ_q, occ_d;

   assign in_hs_s  = axis_s_valid_i & axis_s_ready_o;
   assign out_hs_s = axis_m_valid_o & axis_m_ready_i;

   // Occupancy next-state: +1 per input beat, -1 per output beat.
   always_comb begin
      occ_d = occ_q;
      case ({in_hs_s, out_hs_s})
         2'b10:   occ_d = occ_q + OCC_BITS'(1);
         2'b01:   occ_d = occ_q - OCC_BITS'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         occ_q <= {OCC_BITS{1'b0}};
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy_o = occ_q;

endmodule

// File: tb/tb_axis_pipe_skid.sv
// -----------------------------------------------------------------------------
// tb_axis_pipe_skid
// Randomized and directed stimulus against a queue-based reference model of
// the pipeline: every accepted beat is pushed, every emitted beat must equal
// the head, and the held-beat count must equal occupancy_o.
// -----------------------------------------------------------------------------
module tb_axis_pipe_skid;

   localparam int DB   = 3;
   localparam int DW   = DB * 8;
   localparam int PS   = 2;
   localparam int OW   = $clog2(2 * PS + 1);
   localparam int FULL = 2 * PS;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          s_last;
   logic          s_user;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          m_user;
   logic [OW-1:0] occ;

   always #5 clk_i = ~clk_i;

   axis_pipe_skid #(
      .DATA_BYTES      (DB),
      .PIPELINE_STAGES (PS)
   ) dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .axis_s_data_i  (s_data),
      .axis_s_valid_i (s_valid),
      .axis_s_ready_o (s_ready),
      .axis_s_last_i  (s_last),
      .axis_s_user_i  (s_user),
      .axis_m_data_o  (m_data),
      .axis_m_valid_o (m_valid),
      .axis_m_ready_i (m_ready),
      .axis_m_last_o  (m_last),
      .axis_m_user_o  (m_user),
      .occupancy_o    (occ)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: beats held in flight, with the cycle each was accepted.
   logic [DW+1:0] exp_q[$];
   int            exp_cyc_q[$];
   int            cyc = 0;
   int            n_out = 0;

   // Source controls.
   int            beats_left = 0;
   int            p_valid = 0;
   int            p_ready = 0;
   int            beat_idx = 0;
   bit            rand_data = 1'b0;
   bit            chk_lat = 1'b0;
   logic [DW-1:0] next_val = '0;

   bit            prev_stall = 1'b0;
   logic [DW+1:0] prev_beat = '0;

   // Called at negedge: offer a new beat if none pending, pick downstream ready.
   task automatic prep_inputs();
      if (!s_valid && beats_left > 0 && $urandom_range(99) < p_valid) begin
         s_valid  = 1'b1;
         s_data   = rand_data ? DW'($urandom) : next_val;
         next_val = next_val + 1'b1;
         s_last   = (beat_idx % 640) == 639;
         s_user   = (beat_idx % 2560) == 0;
         beat_idx++;
         beats_left--;
      end
      m_ready = ($urandom_range(99) < p_ready);
   endtask

   // One clock: check outputs against the model, advance the model at the edge.
   task automatic run_cycle();
      bit            in_hs;
      bit            out_hs;
      logic [DW+1:0] obs;
      #1;
      in_hs  = s_valid && s_ready;
      out_hs = m_valid && m_ready;
      obs    = {m_last, m_user, m_data};
      check_eq("occupancy", 32'(occ), 32'(exp_q.size()));
      if (exp_q.size() == 0) check_eq("valid_when_empty", 32'(m_valid), 32'd0);
      if (exp_q.size() == FULL) check_eq("ready_when_full", 32'(s_ready), 32'd0);
      if (prev_stall) begin
         check_eq("stall_valid", 32'(m_valid), 32'd1);
         check_eq("stall_payload", 32'(obs), 32'(prev_beat));
      end
      if (out_hs) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_beat", 32'(m_valid), 32'd0);
         end else begin
            check_eq("beat", 32'(obs), 32'(exp_q[0]));
            if (chk_lat) check_eq("latency", 32'(cyc - exp_cyc_q[0]), 32'(PS));
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = obs;
      @(posedge clk_i);
      if (out_hs && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         void'(exp_cyc_q.pop_front());
         n_out++;
      end
      if (in_hs) begin
         exp_q.push_back({s_last, s_user, s_data});
         exp_cyc_q.push_back(cyc);
      end
      cyc++;
      @(negedge clk_i);
      if (in_hs) s_valid = 1'b0;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) begin
         prep_inputs();
         run_cycle();
      end
   endtask

   // Run until all beats are sent and drained, bounded by max_cycles.
   task automatic run_until_idle(input int max_cycles, input string tag);
      int n = 0;
      while ((beats_left > 0 || s_valid || exp_q.size() > 0) && n < max_cycles) begin
         prep_inputs();
         run_cycle();
         n++;
      end
      check_eq(tag, 32'(beats_left + exp_q.size() + int'(s_valid)), 32'd0);
   endtask

   initial begin
      int out_base;
      rstn_i  = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      s_user  = 1'b0;
      m_ready = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk_i);
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("rst_occ", 32'(occ), 32'd0);
      check_eq("rst_m_last", 32'(m_last), 32'd0);
      check_eq("rst_m_user", 32'(m_user), 32'd0);
      rstn_i = 1'b1;
      #1;
      check_eq("ready_before_edge", 32'(s_ready), 32'd0);
      @(negedge clk_i);
      check_eq("ready_after_release", 32'(s_ready), 32'd1);

      // Unstalled stream 1..16: fixed latency, back-to-back, in order.
      next_val = DW'(1);
      rand_data = 1'b0;
      beats_left = 16;
      p_valid = 100;
      p_ready = 100;
      chk_lat = 1'b1;
      n_out = 0;
      run_until_idle(200, "stream_timeout");
      check_eq("stream_count", 32'(n_out), 32'd16);
      chk_lat = 1'b0;

      // Continuous input with output stalled 10 cycles, then drain.
      beats_left = 1000;
      p_ready = 0;
      run_n(10);
      check_eq("stall_occ_full", 32'(occ), 32'(FULL));
      check_eq("stall_ready_low", 32'(s_ready), 32'd0);
      p_ready = 100;
      run_n(20);
      beats_left = 0;
      run_until_idle(200, "stall_drain_timeout");

      // Single beat held on the output until ready.
      p_valid = 0;
      p_ready = 0;
      s_valid = 1'b1;
      s_data  = 24'hABCDEF;
      s_last  = 1'b1;
      s_user  = 1'b1;
      run_n(8);
      check_eq("hold_valid", 32'(m_valid), 32'd1);
      check_eq("hold_payload", 32'({m_last, m_user, m_data}), 32'({2'b11, 24'hABCDEF}));
      p_ready = 100;
      run_until_idle(50, "hold_timeout");
      check_eq("hold_occ_zero", 32'(occ), 32'd0);

      // Reset with three beats held.
      s_last = 1'b0;
      s_user = 1'b0;
      beats_left = 3;
      p_valid = 100;
      p_ready = 0;
      run_n(3);
      check_eq("pre_reset_occ", 32'(occ), 32'd3);
      #2;
      rstn_i = 1'b0;
      #1;
      check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
      check_eq("midrst_occ", 32'(occ), 32'd0);
      check_eq("midrst_s_ready", 32'(s_ready), 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
      prev_stall = 1'b0;
      s_valid = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      p_ready = 100;
      run_n(10);

      // Random valid/ready at 50% for 10000 beats.
      rand_data = 1'b1;
      beat_idx = 0;
      beats_left = 10000;
      p_valid = 50;
      p_ready = 50;
      out_base = n_out;
      run_until_idle(60000, "random_timeout");
      check_eq("random_count", 32'(n_out - out_base), 32'd10000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
